// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the HMMM core: fixed-priority core access with a
// starvation-bounded loader slot and fixed-latency read sequencing (one read outstanding).
module mem_port_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 16,
    parameter int LAT     = 1,
    parameter int MAXWAIT = 4
) (
    input  logic          ph1,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    typedef enum logic {
        IDLE,
        RDWAIT
    } state_t;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DBG = 1'b1
    } owner_t;

    localparam logic [3:0] WAIT_MAX = 4'(MAXWAIT);
    localparam logic [2:0] LAT_INIT = 3'(LAT);

    state_t     state, state_next;
    owner_t     owner, owner_next;
    logic [2:0] lat_cnt, lat_cnt_next;
    logic [3:0] wait_cnt, wait_cnt_next;

    logic       data_cycle;
    logic       can_grant;
    logic       rd_issue;

    // The last RDWAIT cycle carries the returning data and may also issue a new access.
    assign data_cycle = (state == RDWAIT) && (lat_cnt == 3'd1);
    assign can_grant  = reset && ((state == IDLE) || data_cycle);

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (can_grant) begin
            if (dbg_req && (!cpu_req || (wait_cnt == WAIT_MAX))) begin
                dbg_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en    = cpu_gnt | dbg_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    always_comb begin
        cpu_rvalid = reset && data_cycle && (owner == OWNER_CPU);
        dbg_rvalid = reset && data_cycle && (owner == OWNER_DBG);
        cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
        dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
        busy       = reset && (state == RDWAIT) && !data_cycle;
    end

    assign rd_issue = mem_en && !mem_we;

    always_comb begin
        state_next   = state;
        owner_next   = owner;
        lat_cnt_next = lat_cnt;
        if (rd_issue) begin
            state_next   = RDWAIT;
            owner_next   = dbg_gnt ? OWNER_DBG : OWNER_CPU;
            lat_cnt_next = LAT_INIT;
        end else if (state == RDWAIT) begin
            if (data_cycle) begin
                state_next   = IDLE;
                lat_cnt_next = 3'd0;
            end else begin
                lat_cnt_next = lat_cnt - 3'd1;
            end
        end
    end

    // A grant clears the count even on the cycle it would have saturated.
    always_comb begin
        wait_cnt_next = wait_cnt;
        if (dbg_gnt) begin
            wait_cnt_next = 4'd0;
        end else if (dbg_req && (wait_cnt != WAIT_MAX)) begin
            wait_cnt_next = wait_cnt + 4'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge ph1) begin
        if (!reset) begin
            state    <= IDLE;
            owner    <= OWNER_CPU;
            lat_cnt  <= 3'd0;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            owner    <= owner_next;
            lat_cnt  <= lat_cnt_next;
            wait_cnt <= wait_cnt_next;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (LAT=1,2,3; MAXWAIT=4) share
// stimulus, each with its own behavioural memory; each step checks the relevant instance.
module tb_mem_port_arbiter;

    logic        ph1 = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        dbg_req, dbg_we;
    logic [7:0]  dbg_addr;
    logic [15:0] dbg_wdata;

    logic        cpu_gnt_o    [3];
    logic        cpu_rvalid_o [3];
    logic [15:0] cpu_rdata_o  [3];
    logic        dbg_gnt_o    [3];
    logic        dbg_rvalid_o [3];
    logic [15:0] dbg_rdata_o  [3];
    logic        mem_en_o     [3];
    logic        mem_we_o     [3];
    logic [7:0]  mem_addr_o   [3];
    logic [15:0] mem_wdata_o  [3];
    logic        busy_o       [3];

    int checks   = 0;
    int failures = 0;

    always #5 ph1 = ~ph1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [15:0] mem  [256];
        logic [15:0] pipe [4];

        initial begin
            for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
            for (int i = 0; i < 4; i++) pipe[i] = 16'h0000;
        end

        // Read data appears LAT cycles after the access cycle.
        always @(posedge ph1) begin
            if (mem_en_o[g] && mem_we_o[g]) mem[mem_addr_o[g]] <= mem_wdata_o[g];
            pipe[0] <= (mem_en_o[g] && !mem_we_o[g]) ? mem[mem_addr_o[g]] : 16'hDEAD;
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end

        mem_port_arbiter #(.AW(8), .DW(16), .LAT(g + 1), .MAXWAIT(4)) u_dut (
            .ph1        (ph1),
            .reset      (reset),
            .cpu_req    (cpu_req),
            .cpu_we     (cpu_we),
            .cpu_addr   (cpu_addr),
            .cpu_wdata  (cpu_wdata),
            .cpu_gnt    (cpu_gnt_o[g]),
            .cpu_rvalid (cpu_rvalid_o[g]),
            .cpu_rdata  (cpu_rdata_o[g]),
            .dbg_req    (dbg_req),
            .dbg_we     (dbg_we),
            .dbg_addr   (dbg_addr),
            .dbg_wdata  (dbg_wdata),
            .dbg_gnt    (dbg_gnt_o[g]),
            .dbg_rvalid (dbg_rvalid_o[g]),
            .dbg_rdata  (dbg_rdata_o[g]),
            .mem_en     (mem_en_o[g]),
            .mem_we     (mem_we_o[g]),
            .mem_addr   (mem_addr_o[g]),
            .mem_wdata  (mem_wdata_o[g]),
            .mem_rdata  (pipe[g]),
            .busy       (busy_o[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge ph1);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 16'h0000;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 16'h0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();

        // Reset held with both requesters active: everything quiet.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 16'h1234;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h20; dbg_wdata = 16'h0BAD;
        cyc();
        for (int c = 0; c < 2; c++) begin
            #2;
            for (int g = 0; g < 3; g++) begin
                check($sformatf("rst_cpu_gnt[%0d]", g), 32'(cpu_gnt_o[g]), 32'd0);
                check($sformatf("rst_dbg_gnt[%0d]", g), 32'(dbg_gnt_o[g]), 32'd0);
                check($sformatf("rst_mem_en[%0d]", g), 32'(mem_en_o[g]), 32'd0);
                check($sformatf("rst_rvalid[%0d]", g), 32'(cpu_rvalid_o[g] | dbg_rvalid_o[g]), 32'd0);
                check($sformatf("rst_busy[%0d]", g), 32'(busy_o[g]), 32'd0);
            end
            cyc();
        end

        // First cycle out of reset: core write issues immediately.
        reset = 1'b1;
        dbg_req = 1'b0;
        #2;
        check("t1_cpu_gnt", 32'(cpu_gnt_o[1]), 32'd1);
        check("t1_dbg_gnt", 32'(dbg_gnt_o[1]), 32'd0);
        check("t1_mem_en", 32'(mem_en_o[1]), 32'd1);
        check("t1_mem_we", 32'(mem_we_o[1]), 32'd1);
        check("t1_mem_addr", 32'(mem_addr_o[1]), 32'h10);
        check("t1_mem_wdata", 32'(mem_wdata_o[1]), 32'h1234);
        cyc();

        // LAT=2 read: busy gap, then data and a loader grant together.
        cpu_we = 1'b0;
        #2;
        check("t2_rd_gnt", 32'(cpu_gnt_o[1]), 32'd1);
        check("t2_rd_we", 32'(mem_we_o[1]), 32'd0);
        check("t2_rd_addr", 32'(mem_addr_o[1]), 32'h10);
        cyc();
        cpu_req = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h20; dbg_wdata = 16'hBEEF;
        #2;
        check("t2_busy", 32'(busy_o[1]), 32'd1);
        check("t2_wait_no_dbg_gnt", 32'(dbg_gnt_o[1]), 32'd0);
        check("t2_wait_no_mem_en", 32'(mem_en_o[1]), 32'd0);
        check("t2_wait_no_rvalid", 32'(cpu_rvalid_o[1]), 32'd0);
        cyc();
        #2;
        check("t2_cpu_rvalid", 32'(cpu_rvalid_o[1]), 32'd1);
        check("t2_cpu_rdata", 32'(cpu_rdata_o[1]), 32'h1234);
        check("t2_dbg_rdata_zero", 32'(dbg_rdata_o[1]), 32'd0);
        check("t2_dbg_gnt", 32'(dbg_gnt_o[1]), 32'd1);
        check("t2_dbg_addr", 32'(mem_addr_o[1]), 32'h20);
        check("t2_dbg_wdata", 32'(mem_wdata_o[1]), 32'hBEEF);
        check("t2_busy_done", 32'(busy_o[1]), 32'd0);
        cyc();
        do_reset();

        // Both requesting writes continuously: loader wins every fifth cycle.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 16'h1111;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h40; dbg_wdata = 16'h2222;
        for (int i = 0; i < 10; i++) begin
            #2;
            check($sformatf("t3_cpu_gnt_c%0d", i), 32'(cpu_gnt_o[1]), 32'((i % 5) != 4));
            check($sformatf("t3_dbg_gnt_c%0d", i), 32'(dbg_gnt_o[1]), 32'((i % 5) == 4));
            check($sformatf("t3_addr_c%0d", i), 32'(mem_addr_o[1]), ((i % 5) == 4) ? 32'h40 : 32'h30);
            cyc();
        end
        do_reset();

        // LAT=1 back-to-back core reads alternating between two addresses.
        cpu_req = 1'b1; cpu_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cpu_addr = (i % 2 == 1) ? 8'h30 : 8'h10;
            #2;
            check($sformatf("t4_gnt_c%0d", i), 32'(cpu_gnt_o[0]), 32'd1);
            check($sformatf("t4_rvalid_c%0d", i), 32'(cpu_rvalid_o[0]), 32'(i > 0));
            if (i > 0)
                check($sformatf("t4_rdata_c%0d", i), 32'(cpu_rdata_o[0]),
                      ((i - 1) % 2 == 1) ? 32'h1111 : 32'h1234);
            check($sformatf("t4_dbg_rdata_c%0d", i), 32'(dbg_rdata_o[0]), 32'd0);
            cyc();
        end
        cpu_req = 1'b0;
        #2;
        check("t4_tail_gnt", 32'(cpu_gnt_o[0]), 32'd0);
        check("t4_tail_rvalid", 32'(cpu_rvalid_o[0]), 32'd1);
        check("t4_tail_rdata", 32'(cpu_rdata_o[0]), 32'h1111);
        cyc();
        #2;
        check("t4_end_rvalid", 32'(cpu_rvalid_o[0]), 32'd0);
        cyc();
        do_reset();

        // LAT=3 loader read aborted by reset.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h10;
        #2;
        check("t5_dbg_gnt", 32'(dbg_gnt_o[2]), 32'd1);
        check("t5_dbg_rd", 32'(mem_we_o[2]), 32'd0);
        cyc();
        dbg_req = 1'b0;
        reset = 1'b0;
        #2;
        check("t5_rst_busy", 32'(busy_o[2]), 32'd0);
        check("t5_rst_rvalid", 32'(dbg_rvalid_o[2]), 32'd0);
        cyc();
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h50; cpu_wdata = 16'h5555;
        #2;
        check("t5_cpu_gnt", 32'(cpu_gnt_o[2]), 32'd1);
        check("t5_mem_en", 32'(mem_en_o[2]), 32'd1);
        check("t5_busy", 32'(busy_o[2]), 32'd0);
        check("t5_rvalid_rel", 32'(dbg_rvalid_o[2]), 32'd0);
        cyc();
        cpu_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            check($sformatf("t5_no_rvalid_c%0d", i), 32'(dbg_rvalid_o[2]), 32'd0);
            check($sformatf("t5_no_busy_c%0d", i), 32'(busy_o[2]), 32'd0);
            cyc();
        end
        do_reset();

        // Loader pulse while core read in flight: count holds, then immediate grant.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        #2;
        check("t6_cpu_gnt", 32'(cpu_gnt_o[1]), 32'd1);
        cyc();
        cpu_req = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h60; dbg_wdata = 16'h6666;
        #2;
        check("t6_pulse_no_gnt", 32'(dbg_gnt_o[1]), 32'd0);
        check("t6_pulse_busy", 32'(busy_o[1]), 32'd1);
        cyc();
        dbg_req = 1'b0;
        #2;
        check("t6_drop_no_gnt", 32'(dbg_gnt_o[1]), 32'd0);
        check("t6_drop_no_mem_en", 32'(mem_en_o[1]), 32'd0);
        check("t6_cpu_rvalid", 32'(cpu_rvalid_o[1]), 32'd1);
        check("t6_wait_after_pulse", 32'(g_dut[1].u_dut.wait_cnt), 32'd1);
        cyc();
        #2;
        check("t6_wait_hold", 32'(g_dut[1].u_dut.wait_cnt), 32'd1);
        cyc();
        dbg_req = 1'b1;
        #2;
        check("t6_dbg_gnt", 32'(dbg_gnt_o[1]), 32'd1);
        check("t6_dbg_addr", 32'(mem_addr_o[1]), 32'h60);
        check("t6_dbg_wdata", 32'(mem_wdata_o[1]), 32'h6666);
        cyc();
        dbg_req = 1'b0;
        #2;
        check("t6_wait_cleared", 32'(g_dut[1].u_dut.wait_cnt), 32'd0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
